// File: rtl/drac_pkg.sv
// Shared core-wide widths and the fetch-queue entry layout.
// No logic; types and constants only.
// The entry struct is the single definition used by fetch and decode.
package drac_pkg;

   localparam int ADDR_SIZE         = 40;
   localparam int INST_SIZE         = riscv_pkg::INST_SIZE;
   localparam int FETCH_QUEUE_DEPTH = 4;

   // One fetched instruction as it travels from icache response to decode.
   typedef struct packed {
      logic [ADDR_SIZE-1:0] pc;
      logic [INST_SIZE-1:0] inst;
      logic                 xcp;
   } fetch_entry_t;

endpackage : drac_pkg

// File: rtl/riscv_pkg.sv
// RISC-V architectural constants shared across the core.
// No logic; widths only.
// Consumers import scoped names rather than redefining them.
package riscv_pkg;

   localparam int INST_SIZE = 32;

endpackage : riscv_pkg

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the icache response port and decode.
// Latency: an entry enqueued on edge N is visible on deq_* after edge N (1 cycle), no bypass.
// Backpressure: resp_ready_o drops when full or after a faulting fetch; fetch_stall_o warns one entry early.
module if_fetch_queue #(
   parameter int DEPTH     = drac_pkg::FETCH_QUEUE_DEPTH,
   parameter int ADDR_SIZE = drac_pkg::ADDR_SIZE,
   parameter int INST_SIZE = drac_pkg::INST_SIZE
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       resp_valid_i,
   input  logic [INST_SIZE-1:0]       resp_inst_i,
   input  logic                       resp_xcp_i,
   input  logic [ADDR_SIZE-1:0]       resp_pc_i,
   output logic                       resp_ready_o,
   output logic                       fetch_stall_o,
   input  logic                       deq_ready_i,
   output logic                       deq_valid_o,
   output logic [ADDR_SIZE-1:0]       deq_pc_o,
   output logic [INST_SIZE-1:0]       deq_inst_o,
   output logic                       deq_xcp_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   // DEPTH must be a power of two (>= 2) so the pointers wrap for free.
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);

   drac_pkg::fetch_entry_t mem_q [DEPTH];

   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic             xcp_block_q;

   logic full;
   logic enq;
   logic deq;

   // Full/empty come from the occupancy count, never from pointer compare.
   assign full          = (count_q == CNT_FULL);
   assign deq_valid_o   = (count_q != '0);

   // Ready depends only on registered state, so a full queue refuses input
   // even in a cycle where decode is draining it.
   assign resp_ready_o  = !full && !xcp_block_q;
   assign fetch_stall_o = (count_q >= CNT_STALL) || xcp_block_q;

   // Flush wins over both handshakes; a response arriving with it is dropped.
   assign enq = resp_valid_i && resp_ready_o && !flush_i;
   assign deq = deq_valid_o && deq_ready_i && !flush_i;

   // Head storage drives decode directly; storage is zeroed by reset so
   // these never show X even while deq_valid_o is low.
   assign deq_pc_o   = mem_q[head_q].pc;
   assign deq_inst_o = mem_q[head_q].inst;
   assign deq_xcp_o  = mem_q[head_q].xcp;
   assign count_o    = count_q;

   // Pointer and occupancy bookkeeping; flush returns everything to origin.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq) begin
            tail_q <= tail_q + PTR_W'(1);
         end
         if (deq) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // A faulting fetch freezes intake: nothing past it may be decoded until
   // the pipeline redirects with a flush.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         xcp_block_q <= 1'b0;
      end else if (flush_i) begin
         xcp_block_q <= 1'b0;
      end else if (enq && resp_xcp_i) begin
         xcp_block_q <= 1'b1;
      end
   end

   // Entry storage is written only on enqueue; flush leaves stale data behind.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (enq) begin
         mem_q[tail_q] <= '{pc: resp_pc_i, inst: resp_inst_i, xcp: resp_xcp_i};
      end
   end

endmodule : if_fetch_queue

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue against a queue-based reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task performs its own comparisons.
module tb_if_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 40;
   localparam int IW    = 32;
   localparam int CW    = 3;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          flush_i;
   logic          resp_valid_i;
   logic [IW-1:0] resp_inst_i;
   logic          resp_xcp_i;
   logic [AW-1:0] resp_pc_i;
   logic          resp_ready_o;
   logic          fetch_stall_o;
   logic          deq_ready_i;
   logic          deq_valid_o;
   logic [AW-1:0] deq_pc_o;
   logic [IW-1:0] deq_inst_o;
   logic          deq_xcp_o;
   logic [CW-1:0] count_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] inst;
      logic          xcp;
   } ent_t;

   ent_t mq[$];
   bit   mblock;

   if_fetch_queue #(.DEPTH(DEPTH), .ADDR_SIZE(AW), .INST_SIZE(IW)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .resp_valid_i  (resp_valid_i),
      .resp_inst_i   (resp_inst_i),
      .resp_xcp_i    (resp_xcp_i),
      .resp_pc_i     (resp_pc_i),
      .resp_ready_o  (resp_ready_o),
      .fetch_stall_o (fetch_stall_o),
      .deq_ready_i   (deq_ready_i),
      .deq_valid_o   (deq_valid_o),
      .deq_pc_o      (deq_pc_o),
      .deq_inst_o    (deq_inst_o),
      .deq_xcp_o     (deq_xcp_o),
      .count_o       (count_o)
   );

   always #5 clk_i = ~clk_i;

   // Expected outputs derived from the model's current contents.
   function automatic int exp_count();
      return mq.size();
   endfunction

   function automatic logic exp_ready();
      return (mq.size() < DEPTH) && !mblock;
   endfunction

   function automatic logic exp_stall();
      return (mq.size() >= DEPTH - 1) || mblock;
   endfunction

   // Drive one cycle of inputs, advance the model, and land 1 unit past the edge.
   task automatic drive(input bit v, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                        input bit xcp, input bit dr, input bit fl);
      bit   do_enq;
      bit   do_deq;
      ent_t e;
      resp_valid_i = v;
      resp_pc_i    = pc;
      resp_inst_i  = inst;
      resp_xcp_i   = xcp;
      deq_ready_i  = dr;
      flush_i      = fl;
      if (fl) begin
         mq.delete();
         mblock = 1'b0;
      end else begin
         do_enq = v && (mq.size() < DEPTH) && !mblock;
         do_deq = (mq.size() > 0) && dr;
         if (do_deq) void'(mq.pop_front());
         if (do_enq) begin
            e.pc = pc; e.inst = inst; e.xcp = xcp;
            mq.push_back(e);
            if (xcp) mblock = 1'b1;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input bit dr);
      drive(1'b0, '0, '0, 1'b0, dr, 1'b0);
   endtask

   task automatic flush_all();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      resp_valid_i = 0; resp_pc_i = '0; resp_inst_i = '0; resp_xcp_i = 0;
      deq_ready_i = 0; flush_i = 0;
      mq.delete(); mblock = 0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      checks++; if (resp_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b required=1", resp_ready_o); end
      checks++; if (fetch_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall actual=%b required=0", fetch_stall_o); end
      checks++; if (deq_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", deq_valid_o); end
      checks++; if (deq_pc_o !== '0 || deq_inst_o !== '0 || deq_xcp_o !== 1'b0) begin
         failures++; $display("FAIL reset_data actual=%h/%h/%b required=0/0/0", deq_pc_o, deq_inst_o, deq_xcp_o); end
      checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", count_o); end
   endtask

   task automatic test_single();
      drive(1'b1, 40'h80000000, 32'h00000013, 1'b0, 1'b0, 1'b0);
      checks++; if (deq_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid actual=%b required=1", deq_valid_o); end
      checks++; if (deq_pc_o !== 40'h80000000) begin failures++; $display("FAIL single_pc actual=%h required=80000000", deq_pc_o); end
      checks++; if (deq_inst_o !== 32'h00000013) begin failures++; $display("FAIL single_inst actual=%h required=00000013", deq_inst_o); end
      checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL single_count actual=%0d required=1", count_o); end
      flush_all();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 40'h100 + 40'(4 * i), 32'(100 + i), 1'b0, 1'b0, 1'b0);
         if (i == 1) begin
            checks++; if (fetch_stall_o !== 1'b0) begin failures++; $display("FAIL fill_stall2 actual=%b required=0", fetch_stall_o); end
         end
         if (i == 2) begin
            checks++; if (fetch_stall_o !== 1'b1) begin failures++; $display("FAIL fill_stall3 actual=%b required=1", fetch_stall_o); end
         end
      end
      checks++; if (resp_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready actual=%b required=0", resp_ready_o); end
      checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_count actual=%0d required=4", count_o); end
      drive(1'b1, 40'hDEAD0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_fifth_count actual=%0d required=4", count_o); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (deq_pc_o !== 40'h100 + 40'(4 * i) || deq_inst_o !== 32'(100 + i)) begin
            failures++; $display("FAIL fill_drain%0d actual=%h/%0d required=%h/%0d", i, deq_pc_o, deq_inst_o, 40'h100 + 40'(4 * i), 100 + i); end
         idle(1'b1);
      end
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin
         failures++; $display("FAIL fill_empty actual=%0d/%b required=0/0", count_o, deq_valid_o); end
   endtask

   task automatic test_full_deq();
      for (int i = 0; i < 4; i++) drive(1'b1, 40'h200 + 40'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 40'h2F0, 32'hFF, 1'b0, 1'b1, 1'b0);
      checks++; if (count_o !== 3'd3) begin failures++; $display("FAIL fulldeq_count actual=%0d required=3", count_o); end
      checks++; if (resp_ready_o !== 1'b1) begin failures++; $display("FAIL fulldeq_ready actual=%b required=1", resp_ready_o); end
      checks++; if (deq_pc_o !== 40'h204) begin failures++; $display("FAIL fulldeq_head actual=%h required=204", deq_pc_o); end
      flush_all();
   endtask

   task automatic test_stream();
      drive(1'b1, 40'h0, 32'h1000, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) begin
         checks++; if (deq_pc_o !== 40'(4 * (i - 1))) begin
            failures++; $display("FAIL stream_pc%0d actual=%h required=%h", i, deq_pc_o, 40'(4 * (i - 1))); end
         drive(1'b1, 40'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b1, 1'b0);
         checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL stream_count%0d actual=%0d required=1", i, count_o); end
      end
      checks++; if (deq_pc_o !== 40'h24 || deq_inst_o !== 32'h1009) begin
         failures++; $display("FAIL stream_last actual=%h/%h required=24/1009", deq_pc_o, deq_inst_o); end
      idle(1'b1);
      checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL stream_drain actual=%0d required=0", count_o); end
   endtask

   task automatic test_xcp();
      drive(1'b1, 40'h1000, 32'hABCD, 1'b1, 1'b0, 1'b0);
      checks++; if (resp_ready_o !== 1'b0 || fetch_stall_o !== 1'b1) begin
         failures++; $display("FAIL xcp_block actual=%b/%b required=0/1", resp_ready_o, fetch_stall_o); end
      checks++; if (deq_valid_o !== 1'b1 || deq_xcp_o !== 1'b1 || deq_pc_o !== 40'h1000) begin
         failures++; $display("FAIL xcp_head actual=%b/%b/%h required=1/1/1000", deq_valid_o, deq_xcp_o, deq_pc_o); end
      drive(1'b1, 40'h1004, 32'h1, 1'b0, 1'b1, 1'b0);
      repeat (3) drive(1'b1, 40'h1008, 32'h2, 1'b0, 1'b1, 1'b0);
      checks++; if (count_o !== 3'd0 || resp_ready_o !== 1'b0 || fetch_stall_o !== 1'b1) begin
         failures++; $display("FAIL xcp_hold actual=%0d/%b/%b required=0/0/1", count_o, resp_ready_o, fetch_stall_o); end
      flush_all();
      checks++; if (resp_ready_o !== 1'b1 || fetch_stall_o !== 1'b0) begin
         failures++; $display("FAIL xcp_release actual=%b/%b required=1/0", resp_ready_o, fetch_stall_o); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) drive(1'b1, 40'h3000 + 40'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 40'h3FFC, 32'h77, 1'b0, 1'b0, 1'b1);
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin
         failures++; $display("FAIL flush_clear actual=%0d/%b required=0/0", count_o, deq_valid_o); end
      idle(1'b0);
      checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL flush_dropped actual=%0d required=0", count_o); end
      drive(1'b1, 40'h4000, 32'h88, 1'b0, 1'b0, 1'b0);
      checks++; if (deq_pc_o !== 40'h4000 || count_o !== 3'd1) begin
         failures++; $display("FAIL flush_restart actual=%h/%0d required=4000/1", deq_pc_o, count_o); end
      flush_all();
   endtask

   task automatic test_random();
      int ref_cnt;
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), {8'h0, 32'($urandom)}, 32'($urandom),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 24) == 0));
         ref_cnt = exp_count();
         checks++; if (int'(count_o) !== ref_cnt) begin failures++; $display("FAIL rand_count@%0d actual=%0d required=%0d", n, count_o, ref_cnt); end
         checks++; if (deq_valid_o !== (ref_cnt != 0)) begin failures++; $display("FAIL rand_valid@%0d actual=%b required=%b", n, deq_valid_o, ref_cnt != 0); end
         checks++; if (resp_ready_o !== exp_ready()) begin failures++; $display("FAIL rand_ready@%0d actual=%b required=%b", n, resp_ready_o, exp_ready()); end
         checks++; if (fetch_stall_o !== exp_stall()) begin failures++; $display("FAIL rand_stall@%0d actual=%b required=%b", n, fetch_stall_o, exp_stall()); end
         if (ref_cnt != 0) begin
            checks++; if (deq_pc_o !== mq[0].pc || deq_inst_o !== mq[0].inst || deq_xcp_o !== mq[0].xcp) begin
               failures++; $display("FAIL rand_head@%0d actual=%h/%h/%b required=%h/%h/%b", n,
                  deq_pc_o, deq_inst_o, deq_xcp_o, mq[0].pc, mq[0].inst, mq[0].xcp); end
         end
      end
      flush_all();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 40'h5000, 32'h5, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 40'h5004, 32'h6, 1'b1, 1'b0, 1'b0);
      #2 rst_i = 1'b1;
      #1;
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || deq_pc_o !== '0 || resp_ready_o !== 1'b1) begin
         failures++; $display("FAIL rstmid_async actual=%0d/%b/%h/%b required=0/0/0/1", count_o, deq_valid_o, deq_pc_o, resp_ready_o); end
      mq.delete(); mblock = 0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      idle(1'b1);
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || fetch_stall_o !== 1'b0) begin
         failures++; $display("FAIL rstmid_after actual=%0d/%b/%b required=0/0/0", count_o, deq_valid_o, fetch_stall_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_deq();
      test_stream();
      test_xcp();
      test_flush();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_if_fetch_queue

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter ADDR_SIZE, default 40, width of the PC field.
REQ-003 Parameter INST_SIZE, default 32, width of the instruction field.
REQ-004 clk_i  in  1  the single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 flush_i  in  1  discards all queue contents and clears the exception block.
REQ-007 resp_valid_i  in  1  the icache interface response is valid this cycle.
REQ-008 resp_inst_i  in  INST_SIZE  fetched instruction word.
REQ-009 resp_xcp_i  in  1  an instruction-fetch exception is associated with this response.
REQ-010 resp_pc_i  in  ADDR_SIZE  PC of the response.
REQ-011 resp_ready_o  out  1  the queue accepts an entry this cycle.
REQ-012 fetch_stall_o  out  1  tells the fetch stage to stop issuing new requests.
REQ-013 deq_ready_i  in  1  decode consumes the head entry this cycle.
REQ-014 deq_valid_o  out  1  the head entry is valid.
REQ-015 deq_pc_o / deq_inst_o / deq_xcp_o  out  ADDR_SIZE / INST_SIZE / 1  the head entry fields.
REQ-016 count_o  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Enqueue SHALL occur when resp_valid_i, resp_ready_o and !flush_i are all high; the entry written is {pc, inst, xcp}.
REQ-018 Dequeue SHALL occur when deq_valid_o and deq_ready_i are both high and flush_i is low.
REQ-019 resp_ready_o SHALL be !full && !xcp_block, with no combinational dependence on deq_ready_i, so a full queue refuses input even while it is being dequeued.
REQ-020 deq_valid_o SHALL equal count != 0.
REQ-021 The deq_* outputs SHALL be driven from the head storage with no bypass, so latency from enqueue to deq_valid_o is exactly 1 cycle.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-023 Pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH; full and empty SHALL be derived from count.
REQ-024 When an entry with resp_xcp_i=1 is enqueued, xcp_block SHALL be set; while it is set, no further entries are enqueued until flush_i.
REQ-025 While xcp_block is set, resp_ready_o SHALL be 0 and fetch_stall_o SHALL be 1.
REQ-026 fetch_stall_o SHALL be (count >= DEPTH-1) || xcp_block.
REQ-027 flush_i SHALL have priority over enqueue and dequeue: in the next cycle count=0, pointers=0, xcp_block=0 and deq_valid_o=0.
REQ-028 A response presented in a flush cycle SHALL be dropped.
REQ-029 deq_* data outputs are don't-care while deq_valid_o=0, but SHALL not be X after reset.
REQ-030 Storage SHALL be written only on enqueue; data is not cleared on flush.

Reset
REQ-031 On rst_i assertion, asynchronously: count=0, pointers=0, xcp_block=0, all storage=0.
REQ-032 After reset: resp_ready_o=1, fetch_stall_o=0, deq_valid_o=0, deq_pc_o=0, deq_inst_o=0, deq_xcp_o=0, count_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries with no dequeue afterwards.

Structure
REQ-034 ADDR_SIZE, INST_SIZE, the queue-entry struct {pc, inst, xcp} and the default depth SHALL live in the shared drac_pkg; INST_SIZE comes from riscv_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; storage is a register array indexed by the pointers.

Verification
REQ-036 After reset, enqueue PC 0x80000000 with inst 0x00000013 -> next cycle deq_valid_o=1, deq_pc_o=0x80000000, deq_inst_o=0x00000013, count_o=1.
REQ-037 Enqueue 4 entries with deq_ready_i=0 -> fetch_stall_o=1 after the 3rd entry; after the 4th, resp_ready_o=0 and count_o=4; a 5th response is not accepted and the contents are unchanged.
REQ-038 Full queue with deq_ready_i=1 and resp_valid_i=1 -> only the dequeue happens, count_o goes 4->3, and resp_ready_o=1 the next cycle.
REQ-039 Continuous enq+deq for 10 cycles with PCs 0x0, 0x4 ... 0x24 -> dequeued in order, count_o stays 1, and the pointers wrap correctly.
REQ-040 Enqueue an entry with resp_xcp_i=1 at PC 0x1000 -> resp_ready_o=0 and fetch_stall_o=1; the entry is dequeued with deq_xcp_o=1; the block remains until flush_i.
REQ-041 flush_i with count_o=3 and resp_valid_i=1 in the same cycle -> next cycle count_o=0, deq_valid_o=0, and the flush-cycle response is not present.
